hazard_ctrl_unit: RTL and testbench

Parametrised successor to the fixed 5-stage hazard unit. It adds a per-register latency scoreboard, so multi-cycle producers (loads, multiplier, future FP) stall consumers for exactly the required cycles instead of a hard-coded one-bubble load-use rule. Branch and jump redirects resolve in EX. A redirect that arrives during an I-cache miss is remembered and applied when the fetch completes. Sits beside the datapath and drives every pipeline-latch enable and flush, plus the PC mux select.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_scoreboard.sv | 49 ++++
 rtl/hazard_ctrl_unit.sv | 113 +++++++++++
 tb/tb_hazard_ctrl_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline types for the hazard control slice
package cpu_types_pkg;
    localparam int REG_AW  = 5;
    localparam int MAX_LAT = 7;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef logic [REG_AW-1:0] regbits_t;
    typedef logic [LAT_W-1:0]  lat_t;

    typedef enum logic [1:0] {
        PC_NEXT = 2'b00,
        PC_BR   = 2'b01,
        PC_JR   = 2'b10,
        PC_J    = 2'b11
    } pcsel_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - datapath <-> hazard control signal bundle
interface hazard_ctrl_if #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MAX_LAT  = 7,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int STALL_CW = 16
);
    logic                        ihit;
    logic                        dhit;
    logic                        meldst;
    logic                        de_valid;
    logic [NUM_SRC*REG_AW-1:0]   de_src;
    logic [NUM_SRC-1:0]          de_src_used;
    logic [REG_AW-1:0]           de_rd;
    logic                        de_wen;
    logic [LAT_W-1:0]            de_lat;
    logic                        ex_redirect;
    logic [1:0]                  ex_pcsel;
    logic                        pcen, deen, exen, meen, wben;
    logic                        deflush, exflush, meflush;
    logic [1:0]                  PCSel;
    logic [STALL_CW-1:0]         stall_cycles;

    modport hc (
        input  ihit, dhit, meldst, de_valid, de_src, de_src_used, de_rd, de_wen, de_lat,
               ex_redirect, ex_pcsel,
        output pcen, deen, exen, meen, wben, deflush, exflush, meflush, PCSel, stall_cycles
    );

    modport dp (
        output ihit, dhit, meldst, de_valid, de_src, de_src_used, de_rd, de_wen, de_lat,
               ex_redirect, ex_pcsel,
        input  pcen, deen, exen, meen, wben, deflush, exflush, meflush, PCSel, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register remaining-latency counters with source busy lookup
module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MAX_LAT = 7,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic                      issue,
    input  logic [REG_AW-1:0]         rd,
    input  logic [LAT_W-1:0]          lat,
    input  logic [NUM_SRC*REG_AW-1:0] src,
    output logic [NUM_SRC-1:0]        src_busy
);
    localparam int NUM_REGS = 1 << REG_AW;

    logic [LAT_W-1:0] sb_q [NUM_REGS];
    logic [LAT_W-1:0] sb_d [NUM_REGS];
    logic [LAT_W-1:0] lat_sat;

    assign lat_sat = (int'(lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : lat;

    // A load this cycle overrides the decrement so the newest producer wins.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_d[r] = sb_q[r];
            if (!hold && sb_q[r] != '0)
                sb_d[r] = sb_q[r] - LAT_W'(1);
            if (issue && rd == REG_AW'(r))
                sb_d[r] = lat_sat;
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst)
                sb_q[r] <= '0;
            else
                sb_q[r] <= sb_d[r];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            src_busy[i] = (sb_q[src[i*REG_AW +: REG_AW]] != '0);
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline freeze/flush priority, pending redirect and stall statistics
module hazard_ctrl_unit
    import cpu_types_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MAX_LAT  = 7,
    parameter int LAT_W    = $clog2(MAX_LAT + 1),
    parameter int STALL_CW = 16
) (
    input  logic       CLK,
    input  logic       RST,
    hazard_ctrl_if.hc  bus
);
    logic                dmiss, hazard, issue;
    logic [NUM_SRC-1:0]  src_busy;
    logic                pcen, deen, exen, meen, wben;
    logic                deflush, exflush, meflush;
    pcsel_t              pcsel;
    logic                redir_pend_q, redir_pend_d;
    logic [STALL_CW-1:0] stall_q, stall_d;

    assign dmiss = bus.meldst & ~bus.dhit;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.de_src_used[i] && bus.de_src[i*REG_AW +: REG_AW] != '0 && src_busy[i])
                hazard = 1'b1;
        end
        hazard = hazard & bus.de_valid;
    end

    always_comb begin
        pcen         = 1'b1;
        deen         = 1'b1;
        exen         = 1'b1;
        meen         = 1'b1;
        wben         = 1'b1;
        deflush      = 1'b0;
        exflush      = 1'b0;
        meflush      = 1'b0;
        pcsel        = PC_NEXT;
        redir_pend_d = redir_pend_q;
        if (RST) begin
            {pcen, deen, exen, meen, wben} = '0;
            {deflush, exflush, meflush}    = '1;
            redir_pend_d                   = 1'b0;
        end else if (dmiss) begin
            {pcen, deen, exen, meen, wben} = '0;
        end else if (bus.ex_redirect) begin
            pcsel        = pcsel_t'(bus.ex_pcsel);
            deflush      = 1'b1;
            exflush      = 1'b1;
            redir_pend_d = ~bus.ihit;
        end else if (redir_pend_q) begin
            // The word arriving with ihit was fetched from the old path.
            if (bus.ihit) begin
                deflush      = 1'b1;
                redir_pend_d = 1'b0;
            end else begin
                pcen    = 1'b0;
                deen    = 1'b0;
                exflush = 1'b1;
            end
        end else if (hazard || !bus.ihit) begin
            pcen    = 1'b0;
            deen    = 1'b0;
            exflush = 1'b1;
        end
    end

    assign issue = bus.de_valid & deen & bus.de_wen & (bus.de_rd != '0) & ~deflush & ~exflush;

    hazard_scoreboard #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_sb (
        .clk      (CLK),
        .rst      (RST),
        .hold     (dmiss),
        .issue    (issue),
        .rd       (bus.de_rd),
        .lat      (bus.de_lat),
        .src      (bus.de_src),
        .src_busy (src_busy)
    );

    assign stall_d = (!pcen && stall_q != '1) ? stall_q + STALL_CW'(1) : stall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            redir_pend_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            redir_pend_q <= redir_pend_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.pcen         = pcen;
    assign bus.deen         = deen;
    assign bus.exen         = exen;
    assign bus.meen         = meen;
    assign bus.wben         = wben;
    assign bus.deflush      = deflush;
    assign bus.exflush      = exflush;
    assign bus.meflush      = meflush;
    assign bus.PCSel        = pcsel;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   n_stall;

    hazard_ctrl_if hif ();

    hazard_ctrl_unit u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.ihit        = 1'b1;
        hif.dhit        = 1'b1;
        hif.meldst      = 1'b0;
        hif.de_valid    = 1'b0;
        hif.de_src      = '0;
        hif.de_src_used = '0;
        hif.de_rd       = '0;
        hif.de_wen      = 1'b0;
        hif.de_lat      = '0;
        hif.ex_redirect = 1'b0;
        hif.ex_pcsel    = 2'b00;
    endtask

    task automatic de(input logic [4:0] rd, input logic wen, input logic [2:0] lat,
                      input logic [4:0] s0, input logic [1:0] used);
        hif.de_valid    = 1'b1;
        hif.de_rd       = rd;
        hif.de_wen      = wen;
        hif.de_lat      = lat;
        hif.de_src      = {5'd0, s0};
        hif.de_src_used = used;
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        n_chk  = 0;
        n_pass = 0;
        idle();
        #2;
        check("rst_pcen", hif.pcen, 0);
        check("rst_flush", {hif.deflush, hif.exflush, hif.meflush}, 3'b111);
        check("rst_pcsel", hif.PCSel, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_stall", hif.stall_cycles, 0);
        check("post_rst_pcen", hif.pcen, 1);

        // load r5 lat=1, consumer stalls exactly one cycle
        de(5, 1, 1, 0, 2'b00);
        #1 check("ld_issue_pcen", hif.pcen, 1);
        tick();
        idle();
        de(0, 0, 0, 5, 2'b01);
        #1;
        check("ld_use_pcen", hif.pcen, 0);
        check("ld_use_exflush", hif.exflush, 1);
        tick();
        check("ld_use2_pcen", hif.pcen, 1);
        check("ld_use2_flush", hif.exflush, 0);
        check("ld_use_stall_cnt", hif.stall_cycles, 1);
        tick();
        idle();

        // mult r7 lat=4 with a 3-cycle dmiss in the middle of the stall
        de(7, 1, 4, 0, 2'b00);
        tick();
        n_stall = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            de(0, 0, 0, 7, 2'b01);
            if (i >= 2 && i <= 4) begin
                hif.meldst = 1'b1;
                hif.dhit   = 1'b0;
            end
            #1;
            check($sformatf("mul_pcen_%0d", i), hif.pcen, (i == 7) ? 1 : 0);
            if (i >= 2 && i <= 4) begin
                check($sformatf("mul_sb7_hold_%0d", i), u_dut.u_sb.sb_q[7], 2);
                check($sformatf("mul_dmiss_en_%0d", i), {hif.deen, hif.wben, hif.exflush}, 0);
            end
            if (!hif.pcen)
                n_stall++;
            tick();
        end
        check("mul_stall_total", n_stall, 7);
        check("mul_stall_cnt", hif.stall_cycles, 8);
        idle();

        // jump-register redirect squashes decode writer of r3
        de(3, 1, 2, 0, 2'b00);
        hif.ex_redirect = 1'b1;
        hif.ex_pcsel    = 2'b10;
        #1;
        check("jr_pcsel", hif.PCSel, 2'b10);
        check("jr_flush", {hif.deflush, hif.exflush}, 2'b11);
        check("jr_pcen", hif.pcen, 1);
        tick();
        idle();
        #1;
        check("jr_sb3", u_dut.u_sb.sb_q[3], 0);
        check("jr_after_flush", hif.deflush, 0);
        check("jr_no_pend", u_dut.redir_pend_q, 0);

        // redirect during an I-cache miss
        hif.ex_redirect = 1'b1;
        hif.ex_pcsel    = 2'b01;
        hif.ihit        = 1'b0;
        #1;
        check("br_miss_pcsel", hif.PCSel, 2'b01);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            hif.ihit = 1'b0;
            #1;
            check($sformatf("pend_pcen_%0d", i), hif.pcen, 0);
            check($sformatf("pend_q_%0d", i), u_dut.redir_pend_q, 1);
            tick();
        end
        idle();
        #1;
        check("pend_ihit_deflush", hif.deflush, 1);
        check("pend_ihit_pcen", hif.pcen, 1);
        tick();
        check("pend_clear", u_dut.redir_pend_q, 0);
        check("pend_normal", {hif.pcen, hif.deen, hif.deflush, hif.exflush}, 4'b1100);
        check("pend_stall_cnt", hif.stall_cycles, 11);

        // writer to r0 never blocks
        de(0, 1, 3, 0, 2'b00);
        tick();
        idle();
        de(0, 0, 0, 0, 2'b01);
        #1 check("r0_no_stall", hif.pcen, 1);
        tick();

        // WAW on r9: second producer's latency wins
        de(9, 1, 4, 0, 2'b00);
        tick();
        de(9, 1, 1, 0, 2'b00);
        tick();
        idle();
        de(0, 0, 0, 9, 2'b01);
        #1 check("waw_stall", hif.pcen, 0);
        tick();
        check("waw_free", hif.pcen, 1);
        check("waw_stall_cnt", hif.stall_cycles, 12);
        tick();

        // stall counter saturation
        idle();
        hif.ihit = 1'b0;
        for (int i = 0; i < 70000; i++)
            @(posedge clk);
        #1 check("sat_cnt", hif.stall_cycles, 16'hFFFF);
        tick();
        tick();
        check("sat_hold", hif.stall_cycles, 16'hFFFF);

        // reset in the middle of a stall with a pending redirect
        idle();
        de(4, 1, 7, 0, 2'b00);
        tick();
        idle();
        hif.ex_redirect = 1'b1;
        hif.ihit        = 1'b0;
        tick();
        idle();
        de(0, 0, 0, 4, 2'b01);
        rst = 1'b1;
        #1;
        check("mid_sb4", u_dut.u_sb.sb_q[4], 6);
        check("mid_pend", u_dut.redir_pend_q, 1);
        check("mid_rst_out", {hif.pcen, hif.deflush}, 2'b01);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("mid_rst_sb4", u_dut.u_sb.sb_q[4], 0);
        check("mid_rst_cnt", hif.stall_cycles, 0);
        check("mid_rst_pend", u_dut.redir_pend_q, 0);
        check("mid_rst_pcen", hif.pcen, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
